// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: per-entry tag, 2-bit saturating counter and
// 32-bit target. Zero-latency lookup at fetch, training and mispredict
// detection at execute, plus resolved-branch and mispredict counters.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid   [ENTRIES];
    logic [TAG_W-1:0] tag_mem [ENTRIES];
    logic [1:0]       ctr     [ENTRIES];
    logic [31:0]      tgt     [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;

    // Instructions are word aligned, so the low two PC bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    // Fetch-side lookup: reads only pre-edge table state, never the ex_* inputs.
    always_comb begin
        if_hit      = valid[if_idx] && (tag_mem[if_idx] == if_tag);
        pred_taken  = if_hit && ctr[if_idx][1];
        pred_target = pred_taken ? tgt[if_idx] : if_pc + 32'd4;
    end

    // Execute-side mispredict detection and the corrected fetch address.
    always_comb begin
        ex_hit      = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);
        redirect    = ex_valid && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_target != ex_pred_target)));
        redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
    end

    // Table training, allocation on taken misses, and statistics counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                tag_mem[i] <= '0;
                ctr[i]     <= 2'b00;
                tgt[i]     <= 32'd0;
            end
            br_count  <= 32'd0;
            mis_count <= 32'd0;
        end else begin
            if (ex_valid) begin
                br_count <= sat_inc32(br_count);
                if (ex_hit) begin
                    ctr[ex_idx] <= ex_taken ? sat_inc2(ctr[ex_idx]) : sat_dec2(ctr[ex_idx]);
                    if (ex_taken) begin
                        tgt[ex_idx] <= ex_target;
                    end
                end else if (ex_taken) begin
                    // Direct-mapped: a taken miss evicts whatever lives at this index.
                    valid[ex_idx]   <= 1'b1;
                    tag_mem[ex_idx] <= ex_tag;
                    ctr[ex_idx]     <= 2'b10;
                    tgt[ex_idx]     <= ex_target;
                end
            end
            if (redirect) begin
                mis_count <= sat_inc32(mis_count);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic against a table-of-records reference model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mis_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each slot remembers the full PC that allocated it.
    bit          m_valid [ENTRIES];
    logic [31:0] m_pc    [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .redirect(redirect),
        .redirect_pc(redirect_pc), .br_count(br_count), .mis_count(mis_count)
    );

    always #5 clk = ~clk;

    function automatic int m_slot(input logic [31:0] pc);
        return int'((pc >> 2) % 32'(ENTRIES));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s;
        s = m_slot(pc);
        return m_valid[s] && ((m_pc[s] >> (IDX_W + 2)) == (pc >> (IDX_W + 2)));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[m_slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_redirect();
        return ex_valid && ((ex_taken != ex_pred_taken) ||
                            (ex_taken && ex_target != ex_pred_target));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_pc[i] = 0; m_ctr[i] = 0; m_tgt[i] = 0;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic m_update();
        int s;
        if (!rst_n) begin
            m_reset();
        end else if (ex_valid) begin
            s = m_slot(ex_pc);
            if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
            if (m_redirect() && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
            if (m_hit(ex_pc)) begin
                if (ex_taken) begin
                    m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                    m_tgt[s] = ex_target;
                end else begin
                    m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                end
            end else if (ex_taken) begin
                m_valid[s] = 1; m_pc[s] = ex_pc; m_ctr[s] = 2; m_tgt[s] = ex_target;
            end
        end
    endtask

    // Advance one clock, keeping the model in step with the DUT.
    task automatic cycle();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
        ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tg;
        ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_pc = 32'h100;
        drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        cycle();
        cycle();
        rst_n = 1'b1;
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
        n_checks++;
        if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target: got %h expected 00000104", pred_target); end
        n_checks++;
        if (br_count !== 32'd0 || mis_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_counts: got br=%0d mis=%0d expected 0/0", br_count, mis_count);
        end
    endtask

    task automatic test_allocate();
        if_pc = 32'h300;
        drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        n_checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h80) begin
            n_fail++; $display("FAIL alloc_redirect: got %b/%h expected 1/00000080", redirect, redirect_pc);
        end
        cycle();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h100;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++; $display("FAIL alloc_lookup: got %b/%h expected 1/00000080", pred_taken, pred_target);
        end
        n_checks++;
        if (mis_count !== 32'd1 || br_count !== 32'd1) begin
            n_fail++; $display("FAIL alloc_counts: got br=%0d mis=%0d expected 1/1", br_count, mis_count);
        end
    endtask

    task automatic test_train();
        if_pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            #1;
            n_checks++;
            if (redirect !== 1'b0) begin n_fail++; $display("FAIL train_no_redirect[%0d]: got %b expected 0", i, redirect); end
            cycle();
        end
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (br_count !== 32'd4 || mis_count !== 32'd1) begin
            n_fail++; $display("FAIL train_counts: got br=%0d mis=%0d expected 4/1", br_count, mis_count);
        end
        drive_ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        n_checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h104) begin
            n_fail++; $display("FAIL train_nt_redirect: got %b/%h expected 1/00000104", redirect, redirect_pc);
        end
        cycle();
        drive_ex(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        n_checks++;
        if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_wt_pred: got %b expected 1", pred_taken); end
        cycle();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++; $display("FAIL train_wnt_pred: got %b/%h expected 0/00000104", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        logic [31:0] alias_pc;
        alias_pc = 32'h100 + 32'(4 * ENTRIES);
        if_pc = 32'h100;
        drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        cycle();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            n_fail++; $display("FAIL alias_before: got %b/%h expected 1/00000080", pred_taken, pred_target);
        end
        drive_ex(1'b1, alias_pc, 1'b1, 32'hA0, 1'b0, alias_pc + 32'd4);
        cycle();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++; $display("FAIL alias_evicted: got %b/%h expected 0/00000104", pred_taken, pred_target);
        end
        if_pc = alias_pc;
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'hA0) begin
            n_fail++; $display("FAIL alias_new: got %b/%h expected 1/000000a0", pred_taken, pred_target);
        end
    endtask

    task automatic test_same_cycle();
        if_pc = 32'h200;
        drive_ex(1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
            n_fail++; $display("FAIL same_cycle_old: got %b/%h expected 0/00000204", pred_taken, pred_target);
        end
        cycle();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
            n_fail++; $display("FAIL same_cycle_new: got %b/%h expected 1/00000400", pred_taken, pred_target);
        end
    endtask

    task automatic test_target_mismatch();
        if_pc = 32'h300;
        drive_ex(1'b1, 32'h300, 1'b1, 32'h80, 1'b0, 32'h304);
        cycle();
        drive_ex(1'b1, 32'h300, 1'b1, 32'h90, 1'b1, 32'h80);
        #1;
        n_checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h90) begin
            n_fail++; $display("FAIL tgt_mismatch_redirect: got %b/%h expected 1/00000090", redirect, redirect_pc);
        end
        cycle();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin
            n_fail++; $display("FAIL tgt_mismatch_store: got %b/%h expected 1/00000090", pred_taken, pred_target);
        end
        rst_n = 1'b0;
        drive_ex(1'b1, 32'h300, 1'b1, 32'h500, 1'b1, 32'h90);
        cycle();
        rst_n = 1'b1;
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin
            n_fail++; $display("FAIL midreset_pred: got %b/%h expected 0/00000304", pred_taken, pred_target);
        end
        n_checks++;
        if (br_count !== 32'd0 || mis_count !== 32'd0) begin
            n_fail++; $display("FAIL midreset_counts: got br=%0d mis=%0d expected 0/0", br_count, mis_count);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << 20) + (32'($urandom_range(0, 31)) << 2);
    endfunction

    task automatic test_random();
        logic        ptk;
        logic [31:0] ptg;
        logic        exp_rd;
        for (int n = 0; n < 2000; n++) begin
            rst_n    = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_pc    = rand_pc();
            ex_taken = ($urandom_range(0, 99) < 65);
            ex_target = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} ^ {$urandom_range(0, 1), 31'd0};
            if ($urandom_range(0, 2) == 0) ex_target = m_tgt[m_slot(ex_pc)];
            ptk = m_pred(ex_pc);
            ptg = m_pred_tgt(ex_pc);
            if ($urandom_range(0, 4) == 0) ptk = ~ptk;
            if ($urandom_range(0, 9) == 0) ptg = ptg ^ 32'h10;
            ex_pred_taken  = ptk;
            ex_pred_target = ptg;
            if_pc = ($urandom_range(0, 9) == 0) ? ex_pc : rand_pc();
            #1;
            n_checks++;
            if (pred_taken !== m_pred(if_pc) || pred_target !== m_pred_tgt(if_pc)) begin
                n_fail++;
                $display("FAIL rand_pred[%0d]: pc=%h got %b/%h expected %b/%h", n, if_pc,
                         pred_taken, pred_target, m_pred(if_pc), m_pred_tgt(if_pc));
            end
            exp_rd = m_redirect();
            n_checks++;
            if (redirect !== exp_rd) begin
                n_fail++; $display("FAIL rand_redirect[%0d]: got %b expected %b", n, redirect, exp_rd);
            end
            if (exp_rd) begin
                n_checks++;
                if (redirect_pc !== (ex_taken ? ex_target : ex_pc + 32'd4)) begin
                    n_fail++;
                    $display("FAIL rand_redirect_pc[%0d]: got %h expected %h", n, redirect_pc,
                             ex_taken ? ex_target : ex_pc + 32'd4);
                end
            end
            cycle();
            n_checks++;
            if (br_count !== m_br || mis_count !== m_mis) begin
                n_fail++;
                $display("FAIL rand_counts[%0d]: got br=%0d mis=%0d expected %0d/%0d", n,
                         br_count, mis_count, m_br, m_mis);
            end
        end
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_allocate();
        test_train();
        test_alias();
        test_same_cycle();
        test_target_mismatch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
